// File: rtl/ripple_deskew_pkg.sv
`timescale 1ps/1ps
// Shared defaults, per-bit deskew depth and the aligned result word layout
// for the ripple-carry adder output stage.
package ripple_deskew_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_STAGE_LAT = 1;

    // Flops needed on sum[k] so that it lines up with sum[WIDTH-1] and cout.
    function automatic int bit_delay(input int width, input int stage_lat, input int k);
        return stage_lat * (width - 1 - k);
    endfunction

    typedef struct packed {
        logic                 cout;
        logic [DEF_WIDTH-1:0] sum;
    } result_t;

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ps/1ps
// Small ready/valid FIFO with occupancy count; full/empty come from the count,
// and a push that finds no room (and no pop in the same cycle) is reported as dropped.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             dropped
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = valid & pop_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dropped = push & full & ~do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_sum_deskew.sv
`timescale 1ps/1ps
// Re-aligns the staggered sum bits and cout of the pipelined ripple adder into
// one word, tags it with the delayed launch valid and buffers it for a consumer.
module ripple_sum_deskew
    import ripple_deskew_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int STAGE_LAT  = DEF_STAGE_LAT,
    parameter int FIFO_DEPTH = 4,
    parameter int begin_time = 0,
    parameter int t          = 10,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    output logic [WIDTH:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    fifo_count,
    output logic             overflow
);

    localparam int L = STAGE_LAT * WIDTH;

    logic [WIDTH-1:0] sum_aligned;
    logic [L-1:0]     tag;
    logic             aligned_valid;
    logic             fifo_full;
    logic             dropped;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        localparam int D = bit_delay(WIDTH, STAGE_LAT, k);
        if (D == 0) begin : g_direct
            assign sum_aligned[k] = sum[k];
        end else begin : g_delay
            logic [D-1:0] dl;
            if (D == 1) begin : g_one
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dl <= '0;
                    else        dl <= sum[k];
                end
            end else begin : g_many
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) dl <= '0;
                    else        dl <= {dl[D-2:0], sum[k]};
                end
            end
            assign sum_aligned[k] = dl[D-1];
        end
    end

    // The tag travels the full adder latency so it marks the edge where all bits meet.
    if (L == 1) begin : g_tag_one
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) tag <= '0;
            else        tag <= launch_valid;
        end
    end else begin : g_tag_many
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) tag <= '0;
            else        tag <= {tag[L-2:0], launch_valid};
        end
    end
    assign aligned_valid = tag[L-1];

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aligned_valid),
        .push_data ({cout, sum_aligned}),
        .pop_ready (out_ready),
        .head      (out_data),
        .valid     (out_valid),
        .count     (fifo_count),
        .full      (fifo_full),
        .dropped   (dropped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (dropped) overflow <= 1'b1;
    end

`ifndef SYNTHESIS
    time last_edge;
    bit  seen_edge;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_edge <= 1'b0;
            last_edge <= 0;
        end else begin
            if (seen_edge) begin
                assert ($time - last_edge == time'(t))
                    else $error("clock edge spacing %0t ps, expected %0d ps", $time - last_edge, t);
            end
            if (launch_valid) begin
                assert ($time >= time'(begin_time))
                    else $error("launch_valid at %0t ps precedes begin_time %0d ps", $time, begin_time);
            end
            last_edge <= $time;
            seen_edge <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_sum_deskew.sv
`timescale 1ps/1ps
// Drives staggered adder results from recorded launches and compares the aligned
// FIFO output against a queue model of launched words.
module tb_ripple_sum_deskew;
    import ripple_deskew_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic           clk;
    logic           rst_n;
    logic           launch_valid;
    logic [WIDTH-1:0] sum;
    logic           cout;
    logic [WIDTH:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     fifo_count;
    logic           overflow;

    ripple_sum_deskew #(
        .WIDTH      (WIDTH),
        .STAGE_LAT  (1),
        .FIFO_DEPTH (DEPTH),
        .begin_time (0),
        .t          (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch_valid (launch_valid),
        .sum          (sum),
        .cout         (cout),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      checks = 0;
    int      errors = 0;
    int      ecnt   = 0;
    bit      lv_hist [int];
    result_t w_hist  [int];
    result_t q [$];
    bit      ovf = 1'b0;

    function automatic result_t rand_word();
        return result_t'(9'($urandom));
    endfunction

    function automatic bit launched(input int e);
        return lv_hist.exists(e) && lv_hist[e];
    endfunction

    // One clock: launch word w now; the adder delivers bit k k+1 edges later.
    task automatic step(input bit lv, input bit rdy, input result_t w);
        logic [WIDTH-1:0] s;
        bit do_pop;
        bit do_push;
        lv_hist[ecnt] = lv && rst_n;
        w_hist[ecnt]  = w;
        for (int k = 0; k < WIDTH; k++) begin
            s[k] = w_hist.exists(ecnt - k - 1) ? w_hist[ecnt - k - 1].sum[k] : 1'b0;
        end
        sum          = s;
        cout         = w_hist.exists(ecnt - WIDTH) ? w_hist[ecnt - WIDTH].cout : 1'b0;
        launch_valid = lv && rst_n;
        out_ready    = rdy;
        do_pop  = rdy && (q.size() != 0);
        do_push = launched(ecnt - WIDTH);
        @(posedge clk);
        if (rst_n) begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) q.push_back(w_hist[ecnt - WIDTH]);
                else                  ovf = 1'b1;
            end
        end
        ecnt++;
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        lv_hist.delete();
        ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        step(1'b0, 1'b0, rand_word());
        step(1'b0, 1'b0, rand_word());
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        launch_valid = 1'b0;
        out_ready = 1'b0;
        sum = '0;
        cout = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, fifo_count, overflow, out_data} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b count=%0d ovf=%b data=%h, want all zero",
                     out_valid, fifo_count, overflow, out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int i = 0; i < 22; i++) begin
            step(i == 10, 1'b1, (i == 10) ? result_t'(9'h1A5) : rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL single_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL single_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        result_t words [3] = '{result_t'(9'h000), result_t'(9'h1FF), result_t'(9'h03C)};
        for (int i = 0; i < 24; i++) begin
            step(i >= 10 && i <= 12, 1'b1, (i >= 10 && i <= 12) ? words[i - 10] : rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL b2b_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL b2b_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 34; i++) begin
            step(i >= 10 && i <= 14, i >= 26, rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL fill_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL fill_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
            if (i == 24) begin
                checks++;
                if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_full: got count=%0d ovf=%b want count=4 ovf=1",
                             fifo_count, overflow);
                end
            end
        end
    endtask

    task automatic test_full_push_pop();
        int e5;
        do_reset();
        e5 = ecnt + 4;
        for (int i = 0; i < 24; i++) begin
            step(i < 5, (ecnt == e5 + WIDTH) || i >= 18, rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL fullpp_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL fullpp_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
            if (i == 13) begin
                checks++;
                if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL fullpp_keep: got count=%0d ovf=%b want count=4 ovf=0",
                             fifo_count, overflow);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 14; i++) step(i == 10, 1'b1, rand_word());
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if ({out_valid, fifo_count, overflow} !== 5'd0) begin
            errors++;
            $display("FAIL midreset_async: got v=%b n=%0d o=%b want 0 0 0",
                     out_valid, fifo_count, overflow);
        end
        step(1'b0, 1'b1, rand_word());
        step(1'b0, 1'b1, rand_word());
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== 5'd0) begin
                errors++;
                $display("FAIL midreset_quiet c%0d: got v=%b n=%0d o=%b want 0 0 0",
                         i, out_valid, fifo_count, overflow);
            end
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 28; i++) begin
            step(i == 10 || i == 15, 1'b1, rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL gap_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL gap_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60, rand_word());
            checks++;
            if ({out_valid, fifo_count, overflow} !== {q.size() != 0, 3'(q.size()), ovf}) begin
                errors++;
                $display("FAIL rand_status c%0d: got v=%b n=%0d o=%b want v=%b n=%0d o=%b",
                         i, out_valid, fifo_count, overflow, q.size() != 0, q.size(), ovf);
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data c%0d: got %h want %h", i, out_data, q[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_reset_midflight();
        test_fill_overflow();
        test_full_push_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_sum_deskew.md
Name: ripple_sum_deskew

Overview:
- Downstream stage of the 8-bit clocked ripple-carry adder.
- The adder's bit-serial carry chain is pipelined, one clocked full-adder per bit, so sum[k] appears STAGE_LAT*(k+1) cycles after operand launch and cout appears with sum[WIDTH-1].
- This block re-aligns the staggered sum bits and cout into one parallel word, tags it with the launch valid, and buffers it in a small FIFO.
- The FIFO feeds a ready/valid consumer. The adder pipeline cannot stall, so overflow is detected and flagged.

Parameters:
- WIDTH, 8, adder width in bits (number of full-adder stages)
- STAGE_LAT, 1, clock cycles per full-adder stage
- FIFO_DEPTH, 4, output buffer entries; power of two, >= 2
- begin_time, 0, simulation-only: ps offset of the first valid clock edge; used only by timing assertions
- t, 10, simulation-only: clock period in ps; used only by timing assertions

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- launch_valid  input  1  pulses in the cycle operands enter adder stage 0
- sum  input  WIDTH  staggered sum bits from the adder
- cout  input  1  carry-out from the adder, aligned with sum[WIDTH-1]
- out_data  output  WIDTH+1  {cout, sum} aligned result
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_data when high with out_valid
- fifo_count  output  clog2(FIFO_DEPTH)+1  occupied entries
- overflow  output  1  sticky: an aligned word was dropped

Behaviour:
- Reset: asynchronous assert, synchronous-safe deassert. All deskew flops, tag pipeline and FIFO pointers clear. out_valid=0, out_data=0, fifo_count=0, overflow=0. Words in flight at reset are discarded.
- Timing reference: launch_valid high at edge n. sum[k] is sampled valid at edge n+STAGE_LAT*(k+1). cout is sampled valid at edge n+L, where L=STAGE_LAT*WIDTH.
- Deskew: sum[k] passes through a delay line of STAGE_LAT*(WIDTH-1-k) flops. sum[WIDTH-1] and cout use zero flops. All bits are coherent at edge n+L.
- Tag pipeline: launch_valid is delayed L cycles. Its output, aligned_valid, marks a coherent word at edge n+L.
- Push: at edge n+L, if aligned_valid is high, write {cout, deskewed sum} into the FIFO.
- Latency: with the FIFO empty, out_valid rises and out_data holds the word from cycle n+L+1 onward, i.e. L+1 cycles after launch.
- Throughput: one launch per cycle. Back-to-back launches produce words on consecutive cycles in launch order.
- Pop: on a rising edge where out_valid & out_ready, the read pointer advances. out_data shows the FIFO head combinationally from registered storage. out_data holds its last value when empty; the verifier does not check it while out_valid=0.
- Full with push and no pop: the word is dropped, overflow is set, and overflow stays set until reset. FIFO contents and count are unchanged.
- Full with simultaneous push and pop: both are performed, count stays FIFO_DEPTH, no overflow.
- Empty with simultaneous push and pop: pop is ignored because out_valid=0. Push proceeds and count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are decided by count.
- Timing assertions: in simulation only, a launch_valid edge before begin_time is flagged. Clock edges spaced other than t ps are flagged.

Decomposition:
- Package ripple_deskew_pkg holds:
  - the default WIDTH and STAGE_LAT
  - the function for the per-bit delay, STAGE_LAT*(WIDTH-1-k)
  - the result word typedef {cout, sum}
- Sub-module sync_fifo (ready/valid, count, full/empty) holds the buffer.
- The deskew delay lines are a generate loop in the top module.

Test Plan (WIDTH=8, STAGE_LAT=1, FIFO_DEPTH=4, L=8):
- Single word: launch at cycle 10. Drive sum[k] at cycle 11+k with the bits of 0xA5, cout=1 at cycle 18, out_ready=1 -> out_valid in cycle 19 only, out_data=9'h1A5.
- Back-to-back: launches at cycles 10, 11, 12 with results 0x00/0, 0xFF/1, 0x3C/0 -> out_valid in cycles 19-21, out_data 9'h000, 9'h1FF, 9'h03C in order.
- Fill and overflow: out_ready=0, 5 consecutive launches -> fifo_count reaches 4, overflow=1 from cycle 23. Then out_ready=1 -> exactly the first 4 words drain, in order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 in the cycle a 5th word aligns -> count stays 4, overflow=0, no word lost.
- Reset mid-flight: launch at 10, rst_n low at cycle 14 for 2 cycles -> no out_valid ever, fifo_count=0, overflow=0.
- Gap: launches at 10 and 15 -> out_valid in cycles 19 and 24 only. No spurious word from stale deskew bits.
